// File: rtl/sdram_clk_reset_sequencer_if.sv
// Signal bundle between the SDRAM clock/reset sequencer and the PLL / SDRAM
// clock domain. The sequencer side is the master; the PLL/SDRAM side is the slave.
interface sdram_clk_reset_sequencer_if;
    logic       pll_locked_async;
    logic       pll_rst;
    logic       sdram_rst;
    logic       powerup_done;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    modport master (
        input  pll_locked_async,
        output pll_rst,
        output sdram_rst,
        output powerup_done,
        output ready,
        output fail,
        output retry_count,
        output lock_loss_count
    );

    modport slave (
        output pll_locked_async,
        input  pll_rst,
        input  sdram_rst,
        input  powerup_done,
        input  ready,
        input  fail,
        input  retry_count,
        input  lock_loss_count
    );
endinterface

// File: rtl/sdram_clk_reset_sequencer.sv
// Reset/lock supervisor for the SDRAM clock PLL. Runs on the free-running
// reference clock, pulses the PLL reset, qualifies lock, times the SDRAM
// power-up wait and then releases the SDRAM-domain reset. A lock loss after
// qualification restarts the PLL; repeated lock timeouts end in a sticky FAIL.
module sdram_clk_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int POWERUP_CYCLES      = 5000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    sdram_clk_reset_sequencer_if.master        seq_if
);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_POWERUP,
        ST_RUN,
        ST_FAIL
    } state_t;

    // The shared counter only ever needs to reach (largest duration - 1).
    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B = (LOCK_STABLE_CYCLES > POWERUP_CYCLES) ? LOCK_STABLE_CYCLES : POWERUP_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P + 1);

    // A state lasting N cycles leaves on the edge where the counter shows N-1.
    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [1:0]       MAX_RTY  = 2'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, locked_s_q;
    logic             pll_rst_q, sdram_rst_q, powerup_done_q, ready_q, fail_q;

    // Lock-loss counter holds at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser; nothing downstream looks at the raw lock input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= seq_if.pll_locked_async;
            locked_s_q <= sync1_q;
        end
    end

    // Next-state, counter, retry and loss bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q < MAX_RTY) begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_PLL_RST;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                if (!locked_s_q) state_d = ST_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = ST_POWERUP;
            end
            ST_POWERUP: begin
                // A loss on the final power-up cycle still counts as a loss.
                if (!locked_s_q) begin
                    loss_d  = sat_inc8(loss_q);
                    retry_d = 2'd0;
                    state_d = ST_PLL_RST;
                end else if (cnt_q == PU_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    loss_d  = sat_inc8(loss_q);
                    retry_d = 2'd0;
                    state_d = ST_PLL_RST;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
        // Untimed states park the counter so it never wraps.
        if (state_d != state_q) cnt_d = '0;
        else if (state_q == ST_RUN || state_q == ST_FAIL) cnt_d = cnt_q;
    end

    // State register with outputs decoded from the next state so they move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_PLL_RST;
            cnt_q          <= '0;
            retry_q        <= 2'd0;
            loss_q         <= 8'd0;
            pll_rst_q      <= 1'b1;
            sdram_rst_q    <= 1'b1;
            powerup_done_q <= 1'b0;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            loss_q         <= loss_d;
            pll_rst_q      <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sdram_rst_q    <= !((state_d == ST_POWERUP) || (state_d == ST_RUN));
            powerup_done_q <= (state_d == ST_RUN);
            ready_q        <= (state_d == ST_RUN);
            fail_q         <= (state_d == ST_FAIL);
        end
    end

    assign seq_if.pll_rst         = pll_rst_q;
    assign seq_if.sdram_rst       = sdram_rst_q;
    assign seq_if.powerup_done    = powerup_done_q;
    assign seq_if.ready           = ready_q;
    assign seq_if.fail            = fail_q;
    assign seq_if.retry_count     = retry_q;
    assign seq_if.lock_loss_count = loss_q;

endmodule

// File: tb/tb_sdram_clk_reset_sequencer.sv
// Bench for the SDRAM clock/reset sequencer: directed bring-up, retry, loss and
// reset scenarios followed by randomized lock behaviour, all compared every
// cycle against a phase/elapsed-time model of the sequencer.
module tb_sdram_clk_reset_sequencer;

    localparam int P_PLL = 4;
    localparam int P_TO  = 64;
    localparam int P_STB = 8;
    localparam int P_PU  = 16;
    localparam int P_MAX = 2;

    localparam int PH_PLLRST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_POWERUP = 3, PH_RUN = 4, PH_FAIL = 5;
    localparam int S_PLL = 0, S_SDR = 1, S_PUD = 2, S_RDY = 3, S_FAIL = 4, S_RTY = 5, S_LOSS = 6;
    localparam int LIMIT = 60000;

    logic clk;
    logic rst;
    logic lk;

    sdram_clk_reset_sequencer_if ifc ();
    assign ifc.pll_locked_async = lk;

    sdram_clk_reset_sequencer #(
        .PLL_RST_CYCLES      (P_PLL),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_STB),
        .POWERUP_CYCLES      (P_PU),
        .MAX_RETRIES         (P_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (ifc.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared state (each variable written by exactly one process).
    int  cyc;
    int  checks;
    int  errors;
    bit  done;
    int  n_timeout;
    int  lc_cyc [256];
    int  lc_sel [256];
    int  lc_val [256];
    bit  lc_done[256];
    int  lc_n;

    // Model: phase, edges elapsed in phase, lock history, counters.
    int   m_ph;
    int   m_el;
    logic m_s1, m_s2;
    int   m_retry;
    int   m_loss;

    function automatic string sname(input int sel);
        case (sel)
            S_PLL:   return "pll_rst";
            S_SDR:   return "sdram_rst";
            S_PUD:   return "powerup_done";
            S_RDY:   return "ready";
            S_FAIL:  return "fail";
            S_RTY:   return "retry_count";
            default: return "lock_loss_count";
        endcase
    endfunction

    function automatic logic [7:0] dut_val(input int sel);
        case (sel)
            S_PLL:   return {7'd0, ifc.pll_rst};
            S_SDR:   return {7'd0, ifc.sdram_rst};
            S_PUD:   return {7'd0, ifc.powerup_done};
            S_RDY:   return {7'd0, ifc.ready};
            S_FAIL:  return {7'd0, ifc.fail};
            S_RTY:   return {6'd0, ifc.retry_count};
            default: return ifc.lock_loss_count;
        endcase
    endfunction

    function automatic int exp_val(input int sel);
        case (sel)
            S_PLL:   return (m_ph == PH_PLLRST || m_ph == PH_FAIL) ? 1 : 0;
            S_SDR:   return (m_ph == PH_POWERUP || m_ph == PH_RUN) ? 0 : 1;
            S_PUD:   return (m_ph == PH_RUN) ? 1 : 0;
            S_RDY:   return (m_ph == PH_RUN) ? 1 : 0;
            S_FAIL:  return (m_ph == PH_FAIL) ? 1 : 0;
            S_RTY:   return m_retry;
            default: return m_loss;
        endcase
    endfunction

    task automatic enter(input int ph);
        m_ph = ph;
        m_el = 0;
    endtask

    // One clock edge of the sequencer, in terms of phases and time spent in them.
    task automatic model_step();
        logic ls;
        if (rst) begin
            enter(PH_PLLRST);
            m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0; m_loss = 0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = lk;
            m_el = m_el + 1;
            case (m_ph)
                PH_PLLRST: if (m_el >= P_PLL) enter(PH_WAIT);
                PH_WAIT: begin
                    if (ls) enter(PH_STABLE);
                    else if (m_el >= P_TO) begin
                        if (m_retry < P_MAX) begin m_retry = m_retry + 1; enter(PH_PLLRST); end
                        else enter(PH_FAIL);
                    end
                end
                PH_STABLE: begin
                    if (!ls) enter(PH_WAIT);
                    else if (m_el >= P_STB) enter(PH_POWERUP);
                end
                PH_POWERUP, PH_RUN: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss = m_loss + 1;
                        m_retry = 0;
                        enter(PH_PLLRST);
                    end else if (m_ph == PH_POWERUP && m_el >= P_PU) enter(PH_RUN);
                end
                default: ;
            endcase
        end
    endtask

    // Compare process: model step on each edge, all outputs checked 1 time unit later.
    initial begin
        logic [7:0] a;
        cyc = 0; checks = 0; errors = 0;
        m_ph = PH_PLLRST; m_el = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0; m_loss = 0;
        for (int i = 0; i < 256; i++) lc_done[i] = 1'b0;
        while (!done && cyc < LIMIT) begin
            @(posedge clk);
            cyc = cyc + 1;
            model_step();
            #1;
            for (int s = 0; s < 7; s++) begin
                a = dut_val(s);
                checks = checks + 1;
                if (a !== 8'(exp_val(s))) begin
                    errors = errors + 1;
                    $display("FAIL model %s cycle %0d: got %0d expected %0d", sname(s), cyc, a, exp_val(s));
                end
            end
            for (int i = 0; i < lc_n; i++) begin
                if (!lc_done[i] && lc_cyc[i] == cyc) begin
                    lc_done[i] = 1'b1;
                    a = dut_val(lc_sel[i]);
                    checks = checks + 1;
                    if (a !== 8'(lc_val[i])) begin
                        errors = errors + 1;
                        $display("FAIL literal %s cycle %0d: got %0d expected %0d", sname(lc_sel[i]), cyc, a, lc_val[i]);
                    end
                end
            end
        end
        if (!done) begin
            checks = checks + 1; errors = errors + 1;
            $display("FAIL watchdog: stimulus still running at cycle %0d, expected done", cyc);
        end
        for (int i = 0; i < lc_n; i++) begin
            if (!lc_done[i]) begin
                checks = checks + 1; errors = errors + 1;
                $display("FAIL literal %s cycle %0d: got not-reached expected %0d", sname(lc_sel[i]), lc_cyc[i], lc_val[i]);
            end
        end
        checks = checks + 1;
        if (n_timeout != 0) begin
            errors = errors + 1;
            $display("FAIL phase_wait: got %0d expired waits expected 0", n_timeout);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic sched(input int k, input int sel, input int val);
        if (lc_n < 256) begin
            lc_cyc[lc_n] = k; lc_sel[lc_n] = sel; lc_val[lc_n] = val;
            lc_n = lc_n + 1;
        end
    endtask

    task automatic sched_rst(input int k);
        sched(k, S_PLL, 1); sched(k, S_SDR, 1); sched(k, S_PUD, 0); sched(k, S_RDY, 0);
        sched(k, S_FAIL, 0); sched(k, S_RTY, 0); sched(k, S_LOSS, 0);
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (m_ph != ph) n_timeout = n_timeout + 1;
    endtask

    int R, E, F, G;

    // Stimulus: inputs change on falling edges only.
    initial begin
        done = 1'b0; n_timeout = 0; lc_n = 0;
        rst = 1'b1; lk = 1'b0;

        // Clean bring-up.
        cycles(2);
        sched_rst(cyc + 1);
        cycles(1);
        rst = 1'b0;
        R = cyc + 1;
        sched(R + 2, S_PLL, 1); sched(R + 3, S_PLL, 0); sched(R + 3, S_SDR, 1);
        cycles(10);
        lk = 1'b1; E = cyc + 1;
        sched(E + 9, S_SDR, 1);  sched(E + 10, S_SDR, 0);
        sched(E + 25, S_RDY, 0); sched(E + 26, S_RDY, 1); sched(E + 26, S_PUD, 1);
        sched(E + 26, S_LOSS, 0); sched(E + 26, S_RTY, 0);
        to_cyc(E + 34);

        // Lock loss in RUN, then relock.
        lk = 1'b0; F = cyc + 1;
        sched(F + 1, S_RDY, 1); sched(F + 2, S_RDY, 0); sched(F + 2, S_SDR, 1);
        sched(F + 2, S_PLL, 1); sched(F + 2, S_PUD, 0); sched(F + 2, S_LOSS, 1);
        to_cyc(F + 7);
        lk = 1'b1; E = cyc + 1;
        sched(E + 25, S_RDY, 0); sched(E + 26, S_RDY, 1); sched(E + 26, S_LOSS, 1);
        to_cyc(E + 34);

        // Timeout, retries, FAIL, and recovery through rst.
        lk = 1'b0; rst = 1'b1;
        cycles(2);
        rst = 1'b0; R = cyc + 1;
        sched(R + 3, S_PLL, 0);    sched(R + 66, S_RTY, 0);  sched(R + 67, S_RTY, 1);
        sched(R + 67, S_PLL, 1);   sched(R + 71, S_PLL, 0);  sched(R + 135, S_PLL, 1);
        sched(R + 135, S_RTY, 2);  sched(R + 139, S_PLL, 0); sched(R + 202, S_FAIL, 0);
        sched(R + 203, S_FAIL, 1); sched(R + 203, S_PLL, 1); sched(R + 203, S_SDR, 1);
        sched(R + 203, S_RTY, 2);  sched(R + 225, S_FAIL, 1); sched(R + 225, S_PLL, 1);
        to_cyc(R + 229);
        rst = 1'b1;
        sched_rst(cyc + 1);
        cycles(1);

        // Lock chatter: restarts qualification.
        rst = 1'b0; R = cyc + 1;
        to_cyc(R + 7);
        lk = 1'b1;
        cycles(5);
        lk = 1'b0;
        cycles(1);
        lk = 1'b1; G = cyc + 1;
        sched(G + 9, S_SDR, 1); sched(G + 10, S_SDR, 0); sched(G + 10, S_RTY, 0);

        // Lock loss in POWERUP with the counter at 7.
        to_cyc(G + 15);
        lk = 1'b0;
        sched(G + 17, S_SDR, 0);  sched(G + 17, S_PUD, 0); sched(G + 18, S_LOSS, 1);
        sched(G + 18, S_PLL, 1);  sched(G + 18, S_SDR, 1); sched(G + 18, S_PUD, 0);
        cycles(6);
        lk = 1'b1; E = cyc + 1;

        // rst in POWERUP clears the loss count.
        sched(E + 12, S_LOSS, 1); sched(E + 12, S_SDR, 0);
        to_cyc(E + 12);
        rst = 1'b1;
        sched_rst(cyc + 1);
        cycles(1);
        rst = 1'b0;

        // rst in RUN after a further loss.
        wait_phase(PH_RUN, 100);
        lk = 1'b0;
        cycles(8);
        lk = 1'b1;
        wait_phase(PH_RUN, 100);
        sched(cyc + 1, S_LOSS, 1); sched(cyc + 1, S_RDY, 1);
        cycles(3);
        rst = 1'b1;
        sched_rst(cyc + 1);
        cycles(1);
        rst = 1'b0;

        // Drive the loss counter into saturation with one-cycle glitches in POWERUP.
        for (int i = 0; i < 258; i++) begin
            wait_phase(PH_POWERUP, 200);
            lk = 1'b0;
            cycles(1);
            lk = 1'b1;
            cycles(4);
        end
        wait_phase(PH_RUN, 200);
        sched(cyc + 1, S_LOSS, 255);
        lk = 1'b0;
        cycles(8);
        lk = 1'b1;
        wait_phase(PH_RUN, 200);
        sched(cyc + 1, S_LOSS, 255);
        cycles(2);

        // Randomized lock behaviour with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end
            lk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(40, 150));
            else cycles($urandom_range(1, 20));
        end
        cycles(4);
        done = 1'b1;
    end

endmodule
